// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline and pipe_ctrl: hazard/branch/interrupt requests in,
// per-stage enables, flushes and PC/push selects out.
interface pipe_ctrl_if;
  // Requests from decode hazard unit, ALU stage and interrupt line
  logic       load_use_stall;
  logic       branch_taken;
  logic       ret_alu;
  logic       pc_popped;
  logic       int_req;

  // Sequencing controls back to the pipeline
  logic       pc_write;
  logic       fd_write;
  logic       fd_flush;
  logic       de_flush;
  logic [1:0] pc_src;
  logic [1:0] push_sel;
  logic       int_ack;
  logic       busy;

  modport master (
    output load_use_stall,
    output branch_taken,
    output ret_alu,
    output pc_popped,
    output int_req,
    input  pc_write,
    input  fd_write,
    input  fd_flush,
    input  de_flush,
    input  pc_src,
    input  push_sel,
    input  int_ack,
    input  busy
  );

  modport slave (
    input  load_use_stall,
    input  branch_taken,
    input  ret_alu,
    input  pc_popped,
    input  int_req,
    output pc_write,
    output fd_write,
    output fd_flush,
    output de_flush,
    output pc_src,
    output push_sel,
    output int_ack,
    output busy
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall/flush/PC-source control plus RET wait and interrupt entry.
// Define PIPE_CTRL_INT_EN to build the interrupt path (drain, push PC, push flags, vector).
module pipe_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_ctrl_if.slave bus
);

`ifdef PIPE_CTRL_INT_EN
  typedef enum logic [2:0] {
    StRun,
    StRetWait,
    StIntDrain,
    StIntPushPc,
    StIntPushFlags,
    StIntVector
  } state_e;
`else
  typedef enum logic [0:0] {
    StRun,
    StRetWait
  } state_e;
`endif

  localparam logic [1:0] PcSrcNext   = 2'b00;
  localparam logic [1:0] PcSrcBranch = 2'b01;
  localparam logic [1:0] PcSrcPopped = 2'b10;
  localparam logic [1:0] PcSrcVector = 2'b11;
  localparam logic [1:0] PushNone    = 2'b00;
  localparam logic [1:0] PushPc      = 2'b01;
  localparam logic [1:0] PushFlags   = 2'b10;

  state_e state_q, state_d;

`ifdef PIPE_CTRL_INT_EN
  localparam logic [2:0] DrainInit = 3'(DRAIN_CYCLES - 1);
  logic [2:0] drain_cnt_q, drain_cnt_d;
`endif

  // RUN-state request decode, highest priority first: ret > branch > interrupt > stall
  logic run_ret, run_branch, run_int, run_stall;

  always_comb begin
    run_ret    = bus.ret_alu;
    run_branch = !run_ret && bus.branch_taken;
`ifdef PIPE_CTRL_INT_EN
    run_int    = !run_ret && !bus.branch_taken && bus.int_req;
`else
    run_int    = 1'b0;
`endif
    run_stall  = !run_ret && !bus.branch_taken && !run_int && bus.load_use_stall;
  end

`ifndef PIPE_CTRL_INT_EN
  logic unused_int_req;
  assign unused_int_req = bus.int_req;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
`ifdef PIPE_CTRL_INT_EN
      drain_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
`ifdef PIPE_CTRL_INT_EN
      drain_cnt_q <= drain_cnt_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
`ifdef PIPE_CTRL_INT_EN
    drain_cnt_d = drain_cnt_q;
`endif
    case (state_q)
      StRun: begin
        if (run_ret) begin
          state_d = StRetWait;
`ifdef PIPE_CTRL_INT_EN
        end else if (run_int) begin
          state_d     = StIntDrain;
          drain_cnt_d = DrainInit;
`endif
        end
      end
      StRetWait: begin
        if (bus.pc_popped) begin
          state_d = StRun;
        end
      end
`ifdef PIPE_CTRL_INT_EN
      StIntDrain: begin
        if (drain_cnt_q == 3'd0) begin
          state_d = StIntPushPc;
        end else begin
          drain_cnt_d = drain_cnt_q - 3'd1;
        end
      end
      StIntPushPc:    state_d = StIntPushFlags;
      StIntPushFlags: state_d = StIntVector;
      StIntVector:    state_d = StRun;
`endif
      default:        state_d = StRun;
    endcase
  end

  // Output logic: Mealy in RUN, Moore elsewhere
  logic       pc_write_c;
  logic       fd_write_c;
  logic       fd_flush_c;
  logic       de_flush_c;
  logic [1:0] pc_src_c;
  logic [1:0] push_sel_c;
  logic       int_ack_c;

  always_comb begin
    pc_write_c = 1'b0;
    fd_write_c = 1'b0;
    fd_flush_c = 1'b0;
    de_flush_c = 1'b0;
    pc_src_c   = PcSrcNext;
    push_sel_c = PushNone;
    int_ack_c  = 1'b0;
    case (state_q)
      StRun: begin
        if (run_ret) begin
          fd_flush_c = 1'b1;
          de_flush_c = 1'b1;
        end else if (run_branch) begin
          pc_src_c   = PcSrcBranch;
          pc_write_c = 1'b1;
          fd_flush_c = 1'b1;
          de_flush_c = 1'b1;
        end else if (run_int) begin
          fd_flush_c = 1'b1;
        end else if (run_stall) begin
          de_flush_c = 1'b1;
        end else begin
          pc_write_c = 1'b1;
          fd_write_c = 1'b1;
        end
      end
      StRetWait: begin
        fd_flush_c = 1'b1;
        de_flush_c = 1'b1;
        if (bus.pc_popped) begin
          pc_src_c   = PcSrcPopped;
          pc_write_c = 1'b1;
        end
      end
`ifdef PIPE_CTRL_INT_EN
      StIntDrain: begin
        fd_flush_c = 1'b1;
        de_flush_c = 1'b1;
      end
      StIntPushPc: begin
        fd_flush_c = 1'b1;
        de_flush_c = 1'b1;
        push_sel_c = PushPc;
      end
      StIntPushFlags: begin
        fd_flush_c = 1'b1;
        de_flush_c = 1'b1;
        push_sel_c = PushFlags;
      end
      StIntVector: begin
        pc_src_c   = PcSrcVector;
        pc_write_c = 1'b1;
        int_ack_c  = 1'b1;
        fd_flush_c = 1'b1;
      end
`endif
      default: ;
    endcase
    // A flush only lands if the fetch/decode register is written
    if (fd_flush_c) begin
      fd_write_c = 1'b1;
    end
  end

  // Held reset forces every control inactive, even though RUN would otherwise advance the PC
  assign bus.pc_write = rst_n & pc_write_c;
  assign bus.fd_write = rst_n & fd_write_c;
  assign bus.fd_flush = rst_n & fd_flush_c;
  assign bus.de_flush = rst_n & de_flush_c;
  assign bus.pc_src   = rst_n ? pc_src_c   : PcSrcNext;
  assign bus.push_sel = rst_n ? push_sel_c : PushNone;
  assign bus.int_ack  = rst_n & int_ack_c;
  assign bus.busy     = rst_n & (state_q != StRun);

  drain_range_a : assert property (@(posedge clk) DRAIN_CYCLES >= 1 && DRAIN_CYCLES <= 7);

  flush_writes_a : assert property (@(posedge clk) disable iff (!rst_n)
    bus.fd_flush |-> bus.fd_write);

  ack_vector_a : assert property (@(posedge clk) disable iff (!rst_n)
    bus.int_ack |-> (bus.pc_src == PcSrcVector) && bus.pc_write);

  ack_pulse_a : assert property (@(posedge clk) disable iff (!rst_n)
    bus.int_ack |=> !bus.int_ack);

  push_legal_a : assert property (@(posedge clk) disable iff (!rst_n)
    bus.push_sel != 2'b11);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then randomized traffic, checked each cycle
// against a sequence-position reference model.
module tb_pipe_ctrl;
  localparam int D = 2;
`ifdef PIPE_CTRL_INT_EN
  localparam bit IntEn = 1'b1;
`else
  localparam bit IntEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.DRAIN_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       fd_write;
    logic       fd_flush;
    logic       de_flush;
    logic [1:0] pc_src;
    logic [1:0] push_sel;
    logic       int_ack;
    logic       busy;
  } outs_t;

  typedef struct {
    outs_t exp;
    int    step;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step     = 0;

  // Model: inside a RET wait, or at position k of the interrupt sequence (-1 = none).
  // Positions 0..D-1 drain, D push PC, D+1 push flags, D+2 vector.
  bit m_in_ret  = 1'b0;
  int m_int_pos = -1;

  task automatic push_exp(input outs_t e);
    exp_t x;
    x.exp  = e;
    x.step = step;
    step++;
    sb_q.push_back(x);
  endtask

  task automatic cycle(input logic lus, input logic br, input logic ret, input logic pop,
                       input logic irq);
    outs_t e;
    @(posedge clk);
    #1;
    rst_n              = 1'b1;
    bus.load_use_stall = lus;
    bus.branch_taken   = br;
    bus.ret_alu        = ret;
    bus.pc_popped      = pop;
    bus.int_req        = irq;
    e = '0;
    if (m_in_ret) begin
      e.busy     = 1'b1;
      e.fd_flush = 1'b1;
      e.de_flush = 1'b1;
      if (pop) begin
        e.pc_write = 1'b1;
        e.pc_src   = 2'b10;
        m_in_ret   = 1'b0;
      end
    end else if (m_int_pos >= 0) begin
      e.busy     = 1'b1;
      e.fd_flush = 1'b1;
      if (m_int_pos == D + 2) begin
        e.pc_src   = 2'b11;
        e.pc_write = 1'b1;
        e.int_ack  = 1'b1;
        m_int_pos  = -1;
      end else begin
        e.de_flush = 1'b1;
        if (m_int_pos == D) e.push_sel = 2'b01;
        else if (m_int_pos == D + 1) e.push_sel = 2'b10;
        m_int_pos++;
      end
    end else if (ret) begin
      e.fd_flush = 1'b1;
      e.de_flush = 1'b1;
      m_in_ret   = 1'b1;
    end else if (br) begin
      e.pc_src   = 2'b01;
      e.pc_write = 1'b1;
      e.fd_flush = 1'b1;
      e.de_flush = 1'b1;
    end else if (irq && IntEn) begin
      e.fd_flush = 1'b1;
      m_int_pos  = 0;
    end else if (lus) begin
      e.de_flush = 1'b1;
    end else begin
      e.pc_write = 1'b1;
      e.fd_write = 1'b1;
    end
    if (e.fd_flush) e.fd_write = 1'b1;
    push_exp(e);
  endtask

  // Reset for one cycle with arbitrary inputs: every output must read inactive
  task automatic reset_cycle();
    @(posedge clk);
    #1;
    rst_n              = 1'b0;
    bus.load_use_stall = 1'($urandom_range(1));
    bus.branch_taken   = 1'($urandom_range(1));
    bus.ret_alu        = 1'($urandom_range(1));
    bus.pc_popped      = 1'($urandom_range(1));
    bus.int_req        = 1'($urandom_range(1));
    m_in_ret           = 1'b0;
    m_int_pos          = -1;
    push_exp('0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle against the oldest expectation
  initial begin
    forever begin
      exp_t  e;
      outs_t act;
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e   = sb_q.pop_front();
        act = {bus.pc_write, bus.fd_write, bus.fd_flush, bus.de_flush, bus.pc_src,
               bus.push_sel, bus.int_ack, bus.busy};
        n_checks++;
        if (act === e.exp) begin
          n_pass++;
        end else begin
          $display("FAIL outputs step %0d: got %b required %b (pw fw ff df src push ack busy)",
                   e.step, act, e.exp);
        end
      end
    end
  end

  initial begin
    rst_n              = 1'b0;
    bus.load_use_stall = 1'b0;
    bus.branch_taken   = 1'b0;
    bus.ret_alu        = 1'b0;
    bus.pc_popped      = 1'b0;
    bus.int_req        = 1'b0;

    reset_cycle();
    reset_cycle();
    idle(2);
    // Load-use stall, then branch
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    // RET with pc_popped three cycles later
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    // Minimum RET
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Interrupt; request drops during drain
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(D + 4);
    // ret + int + stall together
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(D + 4);
    // branch + int together
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(D + 4);
    // Reset landing in the push-flags cycle of an interrupt sequence
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(D + 1);
    reset_cycle();
    idle(4);
    // Reset while waiting for a popped PC
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_cycle();
    idle(2);
    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(63) == 0) begin
        reset_cycle();
      end else begin
        cycle($urandom_range(3) == 0, $urandom_range(9) == 0, $urandom_range(11) == 0,
              $urandom_range(2) == 0, $urandom_range(5) == 0);
      end
    end
    repeat (3) @(posedge clk);
    n_checks++;
    if (sb_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL scoreboard_drain: got %0d pending entries required 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
